// File: rtl/flag_unit.sv
// NZCV flag register and branch-condition evaluator for the execute stage.
// Resolves B.cond / CBZ / CBNZ combinationally and registers the decision for the next stage.
module flag_unit #(
  parameter bit FORWARD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       valid,
  input  logic       set_flags,
  input  logic       alu_neg,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  input  logic       br_cond,
  input  logic       cbz,
  input  logic       cbnz,
  input  logic [3:0] cond,
  output logic [3:0] flags_q,
  output logic       taken,
  output logic       taken_q
);

  logic [3:0] alu_flags;
  logic [3:0] eff;
  logic       flag_write;
  logic       cond_true;
  logic       n, z, c, v;

  assign alu_flags  = {alu_neg, alu_zero, alu_carry, alu_ovf};
  assign flag_write = valid & set_flags & ~flush;

  // Forwarding ignores stall so the decision stays stable while the stage is held.
  assign eff = (FORWARD && flag_write) ? alu_flags : flags_q;
  assign {n, z, c, v} = eff;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = z;
      4'd1:  cond_true = ~z;
      4'd2:  cond_true = c;
      4'd3:  cond_true = ~c;
      4'd4:  cond_true = n;
      4'd5:  cond_true = ~n;
      4'd6:  cond_true = v;
      4'd7:  cond_true = ~v;
      4'd8:  cond_true = c & ~z;
      4'd9:  cond_true = ~c | z;
      4'd10: cond_true = (n == v);
      4'd11: cond_true = (n != v);
      4'd12: cond_true = ~z & (n == v);
      4'd13: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  end

  // CBZ/CBNZ look at the Rt pass-through zero flag, never at NZCV.
  assign taken = valid & ~flush &
                 ((br_cond & cond_true) | (cbz & alu_zero) | (cbnz & ~alu_zero));

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      taken_q <= 1'b0;
    end else if (flush) begin
      taken_q <= 1'b0;
    end else if (!stall) begin
      if (valid && set_flags)
        flags_q <= alu_flags;
      taken_q <= taken;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: a FORWARD=1 and a FORWARD=0 instance share stimulus,
// expected register state is queued at drive time and popped after the clock edge.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       reset, stall, flush, valid, set_flags;
  logic       alu_neg, alu_zero, alu_carry, alu_ovf;
  logic       br_cond, cbz, cbnz;
  logic [3:0] cond;
  logic [3:0] flags_q, flags_q_nf;
  logic       taken, taken_nf, taken_q, taken_q_nf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic       tq_f;
    logic       tq_nf;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_flags = 4'b0000;
  logic       m_tq_f  = 1'b0;
  logic       m_tq_nf = 1'b0;

  always #5 clk = ~clk;

  flag_unit #(.FORWARD(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid(valid),
    .set_flags(set_flags), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .br_cond(br_cond), .cbz(cbz),
    .cbnz(cbnz), .cond(cond), .flags_q(flags_q), .taken(taken), .taken_q(taken_q)
  );

  flag_unit #(.FORWARD(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid(valid),
    .set_flags(set_flags), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .br_cond(br_cond), .cbz(cbz),
    .cbnz(cbnz), .cond(cond), .flags_q(flags_q_nf), .taken(taken_nf), .taken_q(taken_q_nf)
  );

  // Reference condition check in the ARM pseudocode form: base test on cond[3:1], inverted by cond[0].
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cd);
    logic r;
    case (cd[3:1])
      3'd0: r = f[2];
      3'd1: r = f[1];
      3'd2: r = f[3];
      3'd3: r = f[0];
      3'd4: r = f[1] && !f[2];
      3'd5: r = (f[3] == f[0]);
      3'd6: r = (f[3] == f[0]) && !f[2];
      default: r = 1'b1;
    endcase
    if (cd[0] && cd != 4'hF) r = !r;
    return r;
  endfunction

  function automatic logic taken_ref(input logic fwd);
    logic [3:0] e;
    e = (fwd && valid && set_flags && !flush) ? {alu_neg, alu_zero, alu_carry, alu_ovf} : m_flags;
    return valid && !flush &&
           ((br_cond && cond_ref(e, cond)) || (cbz && alu_zero) || (cbnz && !alu_zero));
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic r, s, f, vl, sf, an, az, ac, av, b, cz, cnz,
                       input logic [3:0] cd);
    reset = r; stall = s; flush = f; valid = vl; set_flags = sf;
    alu_neg = an; alu_zero = az; alu_carry = ac; alu_ovf = av;
    br_cond = b; cbz = cz; cbnz = cnz; cond = cd;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("[TB] FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, "/flags_q"},    flags_q,           e.flags);
    check({e.tag, "/taken_q"},    {3'b0, taken_q},    {3'b0, e.tq_f});
    check({e.tag, "/flags_q_nf"}, flags_q_nf,        e.flags);
    check({e.tag, "/taken_q_nf"}, {3'b0, taken_q_nf}, {3'b0, e.tq_nf});
  endtask

  // Inputs are already driven at the negedge; check taken, queue the post-edge state, then compare.
  task automatic applyStimulus(input string tag, input bit chk_taken = 1'b1);
    logic tf, tn;
    exp_t e;
    #1;
    tf = taken_ref(1'b1);
    tn = taken_ref(1'b0);
    if ((br_cond + cbz + cbnz) > 1)
      $display("[TB] note %s: illegal decode, more than one branch type asserted", tag);
    if (chk_taken) begin
      check({tag, "/taken"},    {3'b0, taken},    {3'b0, tf});
      check({tag, "/taken_nf"}, {3'b0, taken_nf}, {3'b0, tn});
    end
    if (reset) begin
      m_flags = 4'b0000; m_tq_f = 1'b0; m_tq_nf = 1'b0;
    end else if (flush) begin
      m_tq_f = 1'b0; m_tq_nf = 1'b0;
    end else if (!stall) begin
      if (valid && set_flags) m_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
      m_tq_f = tf; m_tq_nf = tn;
    end
    e.tag = tag; e.flags = m_flags; e.tq_f = m_tq_f; e.tq_nf = m_tq_nf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    setIn(1,0,0,0,0, 0,0,0,0, 0,0,0, 4'd0);
    @(negedge clk);

    // Reset, including reset over stall and flush
    setIn(1,1,1,0,0, 0,0,0,0, 0,0,0, 4'd0); applyStimulus("reset0", 1'b0);
    setIn(1,0,0,0,0, 0,0,0,0, 0,0,0, 4'd0); applyStimulus("reset1", 1'b0);
    check("reset/flags_q", flags_q, 4'b0000);
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd0); applyStimulus("post_reset_beq");
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd1); applyStimulus("post_reset_bne");
    check("post_reset_bne/taken_q", {3'b0, taken_q}, 4'b0001);
    setIn(0,0,0,0,1, 1,0,1,1, 1,0,1, 4'd14); applyStimulus("invalid_no_taken");

    // SUBS 5-5 then dependent branches
    setIn(0,0,0,1,1, 0,1,1,0, 0,0,0, 4'd0); applyStimulus("subs_5_5");
    check("subs_5_5/flags_value", flags_q, 4'b0110);
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd0); applyStimulus("beq_after_subs");
    check("beq_after_subs/taken_q", {3'b0, taken_q}, 4'b0001);
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd8); applyStimulus("bhi_after_subs");

    // Same-cycle forwarding: SUBS 3-7 with B.LT, prior flags 0000
    setIn(1,0,0,0,0, 0,0,0,0, 0,0,0, 4'd0); applyStimulus("reset_fwd", 1'b0);
    setIn(0,0,0,1,1, 1,0,0,0, 1,0,0, 4'd11); applyStimulus("fwd_subs_blt");
    check("fwd_subs_blt/taken_q_fwd", {3'b0, taken_q}, 4'b0001);
    check("fwd_subs_blt/taken_q_nofwd", {3'b0, taken_q_nf}, 4'b0000);

    // CBZ/CBNZ with flags 0100 loaded, which must not matter
    setIn(0,0,0,1,1, 0,1,0,0, 0,0,0, 4'd0); applyStimulus("load_0100");
    setIn(0,0,0,1,0, 0,1,0,0, 0,1,0, 4'd1); applyStimulus("cbz_zero");
    setIn(0,0,0,1,0, 0,1,0,0, 0,0,1, 4'd0); applyStimulus("cbnz_zero");
    setIn(0,0,0,1,0, 0,0,0,0, 0,1,0, 4'd0); applyStimulus("cbz_nonzero");
    setIn(0,0,0,1,0, 0,0,0,0, 0,0,1, 4'd0); applyStimulus("cbnz_nonzero");
    setIn(0,0,0,1,0, 0,0,0,0, 1,1,0, 4'd1); applyStimulus("illegal_bcond_cbz");

    // Stall: taken_q=1 beforehand, SUBS held for 3 cycles then released
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd14); applyStimulus("prestall_bal");
    for (int i = 0; i < 3; i++) begin
      setIn(0,1,0,1,1, 1,0,1,1, 1,0,0, 4'd6); applyStimulus($sformatf("stall%0d", i));
    end
    setIn(0,0,0,1,1, 1,0,1,1, 1,0,0, 4'd6); applyStimulus("stall_release");
    check("stall_release/flags_value", flags_q, 4'b1011);

    // Flush: SUBS killed, taken forced low
    setIn(0,0,1,1,1, 0,1,0,0, 1,1,0, 4'd14); applyStimulus("flush_subs");
    check("flush_subs/flags_kept", flags_q, 4'b1011);

    // Exhaustive NZCV x cond sweep on registered flags, plus forwarded flags
    for (int f = 0; f < 16; f++) begin
      setIn(0,0,0,1,1, f[3],f[2],f[1],f[0], 0,0,0, 4'd0);
      applyStimulus($sformatf("sweep_load_%0d", f));
      for (int cd = 0; cd < 16; cd++) begin
        setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, cd[3:0]);
        applyStimulus($sformatf("sweep_f%0d_c%0d", f, cd));
      end
    end
    for (int f = 0; f < 16; f++) begin
      setIn(0,0,0,1,1, f[3],f[2],f[1],f[0], 1,0,0, f[3:0] ^ 4'd5);
      applyStimulus($sformatf("fwd_sweep_%0d", f));
    end

    // GE/LT spot checks
    setIn(0,0,0,1,1, 1,0,0,1, 0,0,0, 4'd0); applyStimulus("load_n1v1");
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd10); applyStimulus("ge_n1v1");
    check("ge_n1v1/taken_q", {3'b0, taken_q}, 4'b0001);
    setIn(0,0,0,1,1, 1,0,0,0, 0,0,0, 4'd0); applyStimulus("load_n1v0");
    setIn(0,0,0,1,0, 0,0,0,0, 1,0,0, 4'd11); applyStimulus("lt_n1v0");
    check("lt_n1v0/taken_q", {3'b0, taken_q}, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
